// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: resolves EX/WB forwarding at capture, stalls on load-use,
// and holds one instruction for the ALU under a valid/ready handshake.

package riscv_32i_defs_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_ADD  = 4'h0;
  localparam alu_op_t ALU_SUB  = 4'h1;
  localparam alu_op_t ALU_AND  = 4'h2;
  localparam alu_op_t ALU_OR   = 4'h3;
  localparam alu_op_t ALU_XOR  = 4'h4;
  localparam alu_op_t ALU_SLL  = 4'h5;
  localparam alu_op_t ALU_SRL  = 4'h6;
  localparam alu_op_t ALU_SRA  = 4'h7;
  localparam alu_op_t ALU_SLT  = 4'h8;
  localparam alu_op_t ALU_SLTU = 4'h9;
endpackage

module ex_operand_stage
  import riscv_32i_defs_pkg::*;
#(
  parameter int      XLEN   = 32,
  parameter alu_op_t NOP_OP = ALU_ADD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_op,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_use_imm,
  input  logic            in_use_pc,
  input  logic            in_reg_write,
  input  logic            fwd_ex_valid,
  input  logic            fwd_ex_is_load,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] in_a,
  output logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write
);

  logic            valid_q, valid_d;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, rs2_q;
  logic [4:0]      rd_q;
  logic            wr_q;

  logic            hazard, accept, launch;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // A load in EX cannot forward yet; the consumer must wait one cycle.
  always_comb begin
    hazard = 1'b0;
    if (in_valid && fwd_ex_valid && fwd_ex_is_load && (fwd_ex_rd != 5'd0)) begin
      hazard = (fwd_ex_rd == in_rs1_addr) || (!in_use_imm && (fwd_ex_rd == in_rs2_addr));
    end
  end

  assign in_ready = rst_n && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign launch   = valid_q && out_ready;

  always_comb begin
    rs1_fwd = in_rs1_data;
    if (fwd_ex_valid && !fwd_ex_is_load && (fwd_ex_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
      rs1_fwd = fwd_ex_data;
    else if (fwd_wb_valid && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
      rs1_fwd = fwd_wb_data;
  end

  always_comb begin
    rs2_fwd = in_rs2_data;
    if (fwd_ex_valid && !fwd_ex_is_load && (fwd_ex_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
      rs2_fwd = fwd_ex_data;
    else if (fwd_wb_valid && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
      rs2_fwd = fwd_wb_data;
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)       valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (launch) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= NOP_OP;
      a_q     <= '0;
      b_q     <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept && !flush) begin
        op_q  <= in_alu_op;
        a_q   <= in_use_pc  ? in_pc  : rs1_fwd;
        b_q   <= in_use_imm ? in_imm : rs2_fwd;
        rs2_q <= rs2_fwd;
        rd_q  <= in_rd_addr;
        wr_q  <= in_reg_write;
      end
    end
  end

  // Outputs are masked by valid so an empty stage (including during reset) looks like a NOP.
  assign out_valid     = valid_q;
  assign alu_op        = valid_q ? op_q  : NOP_OP;
  assign in_a          = valid_q ? a_q   : '0;
  assign in_b          = valid_q ? b_q   : '0;
  assign out_rs2_data  = valid_q ? rs2_q : '0;
  assign out_rd_addr   = valid_q ? rd_q  : 5'd0;
  assign out_reg_write = valid_q && wr_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding priority, load-use stall, backpressure,
// flush and asynchronous reset, with hand-computed expectations.

module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_use_pc, in_reg_write;
  logic        fwd_ex_valid, fwd_ex_is_load;
  logic [4:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        fwd_wb_valid;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] in_a, in_b, out_rs2_data;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int n_chk  = 0;
  int n_fail = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_reg_write(in_reg_write),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .in_a(in_a), .in_b(in_b), .out_rs2_data(out_rs2_data),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_alu_op = 4'h0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0;
    in_use_imm = 0; in_use_pc = 0; in_reg_write = 0;
    fwd_ex_valid = 0; fwd_ex_is_load = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic add_op(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2);
    idle_inputs();
    in_valid = 1; in_alu_op = 4'h0;
    in_rs1_addr = rs1; in_rs1_data = d1;
    in_rs2_addr = rs2; in_rs2_data = d2;
    in_rd_addr = 5'd5; in_reg_write = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0; out_ready = 1; in_valid = 1;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_reg_write", {31'b0, out_reg_write}, 32'd0);
    tick(); tick();
    #2 rst_n = 1;
    in_valid = 0;
    tick();

    // Plain ADD x1(5) + x2(7)
    add_op(5'd1, 32'd5, 5'd2, 32'd7);
    #1 chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_in_a", in_a, 32'd5);
    chk("t1_in_b", in_b, 32'd7);
    chk("t1_alu_op", {28'b0, alu_op}, 32'd0);
    chk("t1_rd", {27'b0, out_rd_addr}, 32'd5);
    chk("t1_reg_write", {31'b0, out_reg_write}, 32'd1);
    chk("t1_rs2_data", out_rs2_data, 32'd7);

    // Back-to-back, EX beats WB, undefined op passes through
    add_op(5'd3, 32'h11, 5'd2, 32'd7);
    in_alu_op = 4'hF;
    fwd_ex_valid = 1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'hBB;
    #1 chk("t2_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_alu_op", {28'b0, alu_op}, 32'hF);
    chk("t2_ex_prio", in_a, 32'hAA);

    fwd_ex_valid = 0; in_alu_op = 4'h0;
    tick();
    chk("t3_wb_fwd", in_a, 32'hBB);

    in_rs1_addr = 0; in_rs1_data = 32'h33;
    fwd_ex_valid = 1; fwd_ex_rd = 0; fwd_wb_rd = 0;
    tick();
    chk("t4_x0_no_fwd", in_a, 32'h33);

    // PC / immediate muxing; rs2 still forwarded for the store path
    add_op(5'd1, 32'd5, 5'd2, 32'd7);
    in_use_pc = 1; in_pc = 32'h1000; in_use_imm = 1; in_imm = 32'h44;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd2; fwd_wb_data = 32'h55;
    tick();
    chk("t5_in_a_pc", in_a, 32'h1000);
    chk("t5_in_b_imm", in_b, 32'h44);
    chk("t5_rs2_fwd", out_rs2_data, 32'h55);

    // Load-use on rs2 -> stall and one bubble
    add_op(5'd1, 32'd5, 5'd4, 32'd8);
    fwd_ex_valid = 1; fwd_ex_is_load = 1; fwd_ex_rd = 5'd4; fwd_ex_data = 32'hDEAD;
    #1 chk("t6_stall_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("t6_bubble", {31'b0, out_valid}, 32'd0);
    chk("t6_bubble_a", in_a, 32'd0);
    fwd_ex_valid = 0; fwd_wb_valid = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h99;
    #1 chk("t6_resume_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("t6_resume_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_resume_b", in_b, 32'h99);

    // Same load but rs2 unused (immediate) -> no stall
    add_op(5'd1, 32'd5, 5'd4, 32'd8);
    in_use_imm = 1; in_imm = 32'h7;
    fwd_ex_valid = 1; fwd_ex_is_load = 1; fwd_ex_rd = 5'd4;
    #1 chk("t7_no_stall", {31'b0, in_ready}, 32'd1);
    tick();
    chk("t7_valid", {31'b0, out_valid}, 32'd1);
    chk("t7_in_b", in_b, 32'h7);

    // Backpressure: held outputs ignore forwarding changes
    add_op(5'd6, 32'h60, 5'd7, 32'h70);
    tick();
    out_ready = 0;
    add_op(5'd6, 32'h61, 5'd7, 32'h71);
    for (int i = 0; i < 3; i++) begin
      fwd_ex_valid = 1; fwd_ex_rd = 5'd6; fwd_ex_data = 32'hC0 + i;
      fwd_wb_valid = 1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'hD0 + i;
      #1 chk("t8_bp_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("t8_bp_valid", {31'b0, out_valid}, 32'd1);
      chk("t8_bp_a", in_a, 32'h60);
      chk("t8_bp_b", in_b, 32'h70);
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("t8_launch_valid", {31'b0, out_valid}, 32'd0);
    chk("t8_launch_a", in_a, 32'd0);

    // Flush while holding and accepting
    add_op(5'd1, 32'd5, 5'd2, 32'd7);
    in_alu_op = 4'h3;
    tick();
    in_alu_op = 4'h2;
    flush = 1;
    #1 chk("t9_ready_ungated", {31'b0, in_ready}, 32'd1);
    tick();
    flush = 0; in_valid = 0;
    chk("t9_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("t9_flush_op", {28'b0, alu_op}, 32'd0);
    chk("t9_flush_wr", {31'b0, out_reg_write}, 32'd0);
    tick();
    chk("t9_stays_empty", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-hold
    add_op(5'd1, 32'h12, 5'd2, 32'h34);
    out_ready = 0;
    tick();
    in_valid = 0;
    chk("t10_held", in_a, 32'h12);
    #2 rst_n = 0;
    #1;
    chk("t10_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t10_async_a", in_a, 32'd0);
    chk("t10_async_wr", {31'b0, out_reg_write}, 32'd0);
    chk("t10_async_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1;
    out_ready = 1;
    tick();
    chk("t10_no_launch", {31'b0, out_valid}, 32'd0);
    add_op(5'd1, 32'h21, 5'd2, 32'h43);
    tick();
    in_valid = 0;
    chk("t10_post_valid", {31'b0, out_valid}, 32'd1);
    chk("t10_post_b", in_b, 32'h43);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter NOP_OP, default ALU_ADD code from riscv_32i_defs_pkg, the alu_op driven when the stage is empty.
REQ-003 clk  in  1  sole clock, rising edge; one clock, reset is asynchronous and active-low.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 flush  in  1  kill the held and incoming instruction.
REQ-006 in_valid / in_ready  in / out  1 / 1  decode-side handshake.
REQ-007 in_alu_op  in  4  operation (alu_op_t).
REQ-008 in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  register indices.
REQ-009 in_rs1_data, in_rs2_data, in_imm, in_pc  in  XLEN each  register-file reads, immediate, PC.
REQ-010 in_use_imm, in_use_pc, in_reg_write  in  1 each  operand-B-is-imm, operand-A-is-PC, writes rd.
REQ-011 fwd_ex_valid, fwd_ex_is_load  in  1 each  EX/MEM result present, result is a load.
REQ-012 fwd_ex_rd, fwd_wb_rd  in  5 each  destination index of the EX/MEM and MEM/WB results.
REQ-013 fwd_ex_data, fwd_wb_data  in  XLEN each  EX/MEM and MEM/WB result data.
REQ-014 fwd_wb_valid  in  1  MEM/WB result present.
REQ-015 out_valid / out_ready  out / in  1 / 1  ALU-side handshake.
REQ-016 alu_op  out  4  drives ALU alu_op.
REQ-017 in_a, in_b  out  XLEN each  drive ALU in_a / in_b.
REQ-018 out_rs2_data  out  XLEN  forwarded rs2 value for stores.
REQ-019 out_rd_addr  out  5  destination index.
REQ-020 out_reg_write  out  1  destination write enable.

Function
REQ-021 Single-entry pipeline register; accepted transfer = in_valid && in_ready, launched transfer = out_valid && out_ready.
REQ-022 in_ready = !hazard && (!out_valid || out_ready), combinational; accepted data appears on outputs the next cycle (latency 1).
REQ-023 hazard = in_valid && fwd_ex_valid && fwd_ex_is_load && fwd_ex_rd != 0 && fwd_ex_rd matches in_rs1_addr, or matches in_rs2_addr when !in_use_imm.
REQ-024 While hazard holds, nothing is accepted; if the held entry launches the same cycle, out_valid falls (bubble).
REQ-025 Forwarded rsX = fwd_ex_data if fwd_ex_valid && !fwd_ex_is_load && fwd_ex_rd == in_rsX_addr != 0; else fwd_wb_data if fwd_wb_valid && fwd_wb_rd == in_rsX_addr != 0; else in_rsX_data. EX has priority over WB.
REQ-026 Index 0 is never forwarded; forwarded rs1/rs2 for index 0 is in_rsX_data.
REQ-027 in_a captured = in_pc if in_use_pc, else forwarded rs1; in_b captured = in_imm if in_use_imm, else forwarded rs2; out_rs2_data = forwarded rs2 always.
REQ-028 Forwarding is resolved only at capture; held outputs stay stable while out_valid && !out_ready regardless of forwarding inputs.
REQ-029 Empty stage (out_valid = 0) drives alu_op = NOP_OP, in_a = in_b = out_rs2_data = 0, out_rd_addr = 0, out_reg_write = 0.
REQ-030 Simultaneous launch and accept the same cycle: new entry replaces old, out_valid stays 1, no bubble.
REQ-031 flush has priority: next cycle out_valid = 0 and outputs take the empty values; any same-cycle accept is discarded; in_ready is not gated by flush.
REQ-032 in_alu_op is passed through unmodified, including undefined codes such as 4'b1111.

Reset
REQ-033 rst_n low asynchronously clears out_valid and forces all outputs to the empty values of REQ-029.
REQ-034 While rst_n is low, in_ready = 0; the first accept is possible on the first rising edge after rst_n rises.
REQ-035 Reset asserted mid-hold drops the held entry with no launch.

Verification
REQ-036 Back-to-back: ADD rs1 = x1 (data 5), rs2 = x2 (data 7), out_ready = 1 -> next cycle out_valid = 1, in_a = 5, in_b = 7, alu_op = ADD code.
REQ-037 Forward priority: rs1 = x3, fwd_ex_rd = 3 (data 0xAA), fwd_wb_rd = 3 (data 0xBB) -> in_a = 0xAA; with fwd_ex_valid = 0 -> in_a = 0xBB; with rs1 = x0 and both forwarding x0 -> in_a = in_rs1_data.
REQ-038 Load-use: fwd_ex_is_load = 1, fwd_ex_rd = 4, in_rs2_addr = 4, in_use_imm = 0 -> in_ready = 0 and one bubble; with in_use_imm = 1 -> no stall.
REQ-039 Backpressure: out_ready = 0 for 3 cycles while forwarding data changes -> in_a and in_b unchanged, in_ready = 0, then launch on out_ready = 1.
REQ-040 flush while holding and accepting -> next cycle out_valid = 0, alu_op = NOP_OP, out_reg_write = 0.
REQ-041 rst_n pulsed low mid-hold, asynchronous to clk -> outputs clear immediately without waiting for an edge.
